mem_bus_arbiter: RTL and testbench

- Shares the single external memory port between three requesters: core instruction fetch (I), core load/store (D) and an auxiliary master (X: cache writeback, debug or DMA).
- Sits between the execute stage's memory interface and the memory/IO fabric.
- Arbitrates with fixed priority plus a starvation guard for X.
- Registers the winning request onto the port and returns completion pulses and read data to the owner.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_bus_prio_pick.sv | 15 +
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: owner/state encodings and default limits shared by the memory bus arbiter.
package mem_bus_pkg;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2,
        OWN_X    = 2'd3
    } owner_e;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;
    localparam int GB_D = 0;
    localparam int GB_I = 1;
    localparam int GB_X = 2;
    localparam int STARVE_LIM_DEF = 8;
    localparam int TIMEOUT_DEF    = 64;
endpackage

// File: rtl/mem_bus_prio_pick.sv
// mem_bus_prio_pick: fixed D > I > X priority, with X lifted to the top when promoted.
module mem_bus_prio_pick
    import mem_bus_pkg::*;
(
    input  logic [2:0] elig,
    input  logic       x_promote,
    output logic [2:0] gnt
);
    always_comb begin
        gnt = '0;
        gnt[GB_X] = elig[GB_X] && (x_promote || !(elig[GB_D] || elig[GB_I]));
        gnt[GB_D] = elig[GB_D] && !gnt[GB_X];
        gnt[GB_I] = elig[GB_I] && !gnt[GB_X] && !elig[GB_D];
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port among fetch (I), load/store (D) and aux (X) masters.
// Define MEM_BUS_TIMEOUT_EN to add the no-ack timeout that completes a transfer with bus_err.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int RV         = 32,
    parameter int VA         = 32,
    parameter int AW         = VA - RV / 16,
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [RV-1:0]   d_wdata,
    input  logic [RV/8-1:0] d_wmask,
    input  logic            d_io,
    output logic            d_done,
    input  logic            x_req,
    input  logic            x_we,
    input  logic [AW-1:0]   x_addr,
    input  logic [RV-1:0]   x_wdata,
    input  logic [RV/8-1:0] x_wmask,
    output logic            x_done,
    output logic [RV-1:0]   rdata,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [RV-1:0]   mem_wdata,
    output logic [RV/8-1:0] mem_wmask,
    output logic            mem_io,
    input  logic            mem_ack,
    input  logic [RV-1:0]   mem_rdata
);
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam int MW = RV / 8;

    state_t        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d, mem_io_q, mem_io_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [RV-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic [MW-1:0] mem_wmask_q, mem_wmask_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [2:0]    elig, gnt;
    logic          tmo_hit;

    assign d_done    = (state_q == DONE) && (owner_q == OWN_D);
    assign i_done    = (state_q == DONE) && (owner_q == OWN_I);
    assign x_done    = (state_q == DONE) && (owner_q == OWN_X);
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_io    = mem_io_q;

    // Gating by IDLE keeps the grant vector quiet mid-transfer, so late requests cannot disturb the counter.
    assign elig = {x_req & ~x_done, i_req & ~i_done, d_req & ~d_done} & {3{state_q == IDLE}};

    mem_bus_prio_pick u_pick (
        .elig      (elig),
        .x_promote (starve_q == CW'(STARVE_LIM)),
        .gnt       (gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        mem_io_d    = mem_io_q;
        rdata_d     = rdata_q;
        starve_d    = (!x_req || gnt[GB_X]) ? '0 :
                      (state_q == IDLE && starve_q != CW'(STARVE_LIM)) ? starve_q + 1'b1 : starve_q;
        if (state_q == IDLE) begin
            owner_d = gnt[GB_D] ? OWN_D : gnt[GB_I] ? OWN_I : gnt[GB_X] ? OWN_X : OWN_NONE;
            if (|gnt) begin
                state_d     = BUSY;
                mem_req_d   = 1'b1;
                mem_we_d    = gnt[GB_D] ? d_we : (gnt[GB_X] && x_we);
                mem_addr_d  = gnt[GB_D] ? d_addr : gnt[GB_I] ? i_addr : x_addr;
                mem_wdata_d = gnt[GB_D] ? d_wdata : gnt[GB_X] ? x_wdata : '0;
                mem_wmask_d = !mem_we_d ? '1 : gnt[GB_D] ? d_wmask : x_wmask;
                mem_io_d    = gnt[GB_D] && d_io;
            end
        end else if (state_q == BUSY) begin
            if (mem_ack || tmo_hit) begin
                state_d   = DONE;
                mem_req_d = 1'b0;
                rdata_d   = mem_ack ? mem_rdata : '0;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            mem_io_q    <= 1'b0;
            rdata_q     <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            mem_io_q    <= mem_io_d;
            rdata_q     <= rdata_d;
            starve_q    <= starve_d;
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    assign tmo_hit = (state_q == BUSY) && !mem_ack && (tmo_q == TW'(TIMEOUT - 1));
    assign bus_err = (state_q == DONE) && err_q;
    always_comb begin
        tmo_d = (state_q == BUSY) ? tmo_q + 1'b1 : '0;
        err_d = (state_q == BUSY) ? tmo_hit : err_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // Without the counter TIMEOUT has no effect; this folds to a constant 0.
    assign bus_err = (TIMEOUT < 0);
`endif

    d_held: assert property (@(posedge clk) disable iff (!reset) (state_q == BUSY && owner_q == OWN_D) |-> d_req);
    i_held: assert property (@(posedge clk) disable iff (!reset) (state_q == BUSY && owner_q == OWN_I) |-> i_req);
    x_held: assert property (@(posedge clk) disable iff (!reset) (state_q == BUSY && owner_q == OWN_X) |-> x_req);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, port fields, starvation promotion and reset.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, x_req = 1'b0;
    logic        d_we = 1'b0, d_io = 1'b0, x_we = 1'b0, mem_ack = 1'b0;
    logic [29:0] i_addr = '0, d_addr = '0, x_addr = '0;
    logic [31:0] d_wdata = '0, x_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_wmask = '0, x_wmask = '0;
    logic        i_done, d_done, x_done, bus_err, mem_req, mem_we, mem_io;
    logic [31:0] rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask), .d_io(d_io), .d_done(d_done),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_wmask(x_wmask), .x_done(x_done),
        .rdata(rdata), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_io(mem_io), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   seq [10];
        int   at  [10];
        int   exp_seq [10] = '{1, 2, 1, 2, 1, 2, 1, 2, 3, 1};
        int   n;
        logic dp, ip, xp;
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_done", {i_done, d_done, x_done, bus_err}, 0);
        chk("rst_port", {mem_we, mem_io, mem_addr, mem_wdata, mem_wmask}, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1'b1;
        @(negedge clk);
        // single fetch read, ack one cycle after mem_req
        i_req = 1'b1; i_addr = 30'h10;
        @(negedge clk);
        chk("i_mreq", mem_req, 1);
        chk("i_addr", mem_addr, 30'h10);
        chk("i_mask", mem_wmask, 4'hF);
        chk("i_we_io", {mem_we, mem_io}, 0);
        @(negedge clk);
        chk("i_hold", mem_req, 1);
        chk("i_early", i_done, 0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0; i_req = 1'b0;
        chk("i_done", i_done, 1);
        chk("i_rdata", rdata, 32'hDEADBEEF);
        chk("i_drop", mem_req, 0);
        @(negedge clk);
        chk("i_pulse", i_done, 0);
        chk("i_rhold", rdata, 32'hDEADBEEF);
        // D write and I read arrive together
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'h12345678; d_wmask = 4'b0100;
        i_req = 1'b1; i_addr = 30'h44;
        @(negedge clk);
        chk("dw_addr", mem_addr, 30'h20);
        chk("dw_we", mem_we, 1);
        chk("dw_wdata", mem_wdata, 32'h12345678);
        chk("dw_mask", mem_wmask, 4'b0100);
        chk("dw_io", mem_io, 0);
        mem_ack = 1'b1; mem_rdata = 32'h0;
        @(negedge clk);
        chk("dw_done", {d_done, i_done}, 2'b10);
        chk("dw_drop", mem_req, 0);
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("gap_idle", {mem_req, d_done, i_done}, 0);
        @(negedge clk);
        chk("i2_addr", mem_addr, 30'h44);
        chk("i2_fields", {mem_req, mem_we, mem_wmask}, 6'b10_1111);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        chk("i2_done", i_done, 1);
        chk("i2_rdata", rdata, 32'hCAFE0001);
        i_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        // I beats X at equal standing; X write follows
        i_req = 1'b1; i_addr = 30'h08;
        x_req = 1'b1; x_we = 1'b1; x_addr = 30'h55; x_wdata = 32'hA5A5A5A5; x_wmask = 4'b0011;
        @(negedge clk);
        chk("ix_first", mem_addr, 30'h08);
        chk("ix_we", mem_we, 0);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("ix_idone", {i_done, x_done}, 2'b10);
        i_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("x_addr", mem_addr, 30'h55);
        chk("x_we", mem_we, 1);
        chk("x_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("x_mask", mem_wmask, 4'b0011);
        mem_ack = 1'b1; mem_rdata = 32'h11;
        @(negedge clk);
        chk("x_done", x_done, 1);
        x_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        // D IO read with wait states; fields stay stable
        d_req = 1'b1; d_we = 1'b0; d_io = 1'b1; d_addr = 30'h3FF; d_wmask = 4'b0001;
        @(negedge clk);
        chk("dio_io", mem_io, 1);
        chk("dio_mask", mem_wmask, 4'hF);
        chk("dio_addr", mem_addr, 30'h3FF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("dio_wait", {mem_req, d_done}, 2'b10);
            chk("dio_stable", mem_addr, 30'h3FF);
        end
        mem_ack = 1'b1; mem_rdata = 32'h87654321;
        @(negedge clk);
        chk("dio_done", d_done, 1);
        chk("dio_rdata", rdata, 32'h87654321);
        d_req = 1'b0; d_io = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
`ifdef MEM_BUS_TIMEOUT_EN
        d_req = 1'b1; d_addr = 30'h40;
        n = 0;
        while (!d_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, 65);
        chk("tmo_err", bus_err, 1);
        chk("tmo_rdata", rdata, 0);
        chk("tmo_req", mem_req, 0);
        d_req = 1'b0;
        @(negedge clk);
        chk("tmo_clear", bus_err, 0);
        i_req = 1'b1; i_addr = 30'h44;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h5;
        @(negedge clk);
        chk("tmo_next", {i_done, bus_err}, 2'b10);
        chk("tmo_nrdata", rdata, 32'h5);
        i_req = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
`endif
        // zero-wait memory, D/I alternate while X waits for promotion
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        d_addr = 30'h100; i_addr = 30'h200; x_addr = 30'h300; x_we = 1'b1;
        d_req = 1'b1; i_req = 1'b1; x_req = 1'b1;
        dp = 1'b0; ip = 1'b0; xp = 1'b0; n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (c + 1 == 25) chk("xs_addr", {mem_req, mem_we, mem_addr}, {2'b11, 30'h300});
            if (d_done || i_done || x_done) begin
                seq[n] = d_done ? 1 : i_done ? 2 : 3;
                at[n]  = c + 1;
                n++;
            end
            d_req = !d_done && !dp; i_req = !i_done && !ip; x_req = !x_done && !xp;
            dp = d_done; ip = i_done; xp = x_done;
        end
        d_req = 1'b0; i_req = 1'b0; x_req = 1'b0; mem_ack = 1'b0;
        chk("xs_count", n, 10);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("xs_owner%0d", j), seq[j], exp_seq[j]);
            chk($sformatf("xs_cycle%0d", j), at[j], 3 * j + 2);
        end
        @(negedge clk);
        // reset during BUSY, then a stray ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'h30;
        @(negedge clk);
        chk("rb_busy", mem_req, 1);
        reset = 1'b0; d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rb_req", mem_req, 0);
        chk("rb_port", {mem_addr, mem_wmask}, 0);
        chk("rb_rdata", rdata, 0);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("rb_late", {d_done, i_done, x_done, mem_req}, 0);
        chk("rb_late_rd", rdata, 0);
        mem_ack = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
